// File: rtl/dcp_instruction_fetch_if.sv
// Bus bundle between the DCP fetch unit, the RAM arbiter read port and the DCP executor.
// master = fetch unit; slave = RAM/executor side.
interface dcp_instruction_fetch_if;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr_data,
    input  mem_ack, mem_data, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_data,
    output mem_ack, mem_data, instr_ready
  );
endinterface

// File: rtl/dcp_instruction_fetch.sv
// DCP instruction fetch: reads 32-bit display control instructions as two 16-bit RAM words
// into a small FIFO and honours executor jump/stop requests.
module dcp_instruction_fetch #(
  parameter logic [22:0] START_ADDR = 23'h000400,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          field_start,
  dcp_instruction_fetch_if.master       bus,
  input  logic                          reload_valid,
  input  logic [22:0]                   reload_addr,
  input  logic                          stop,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, DRAIN} state_t;

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_t        state, state_d;
  logic [22:0]   ptr, ptr_d;
  logic [22:0]   dr_addr, dr_addr_d;
  logic [22:0]   dr_tgt, dr_tgt_d;
  logic          dr_idle, dr_idle_d;
  logic [15:0]   hi, hi_d;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fifo_mem [FIFO_DEPTH];

  logic          flush, push, pop, full, outstanding;
  logic          ev, ev_idle;
  logic [22:0]   ev_addr;

  assign full            = (count == CW'(FIFO_DEPTH));
  assign pop             = bus.instr_valid && bus.instr_ready;
  assign bus.instr_valid = (count != '0);
  assign bus.instr_data  = bus.instr_valid ? fifo_mem[rd_ptr] : '0;
  assign busy            = (state != IDLE);
  assign outstanding     = bus.mem_req && !bus.mem_ack;

  // RD_HI only requests when a whole instruction fits, so RD_LO never overflows the FIFO.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    unique case (state)
      IDLE:  ;
      RD_HI: begin bus.mem_req = !full; bus.mem_addr = ptr;          end
      RD_LO: begin bus.mem_req = 1'b1;  bus.mem_addr = ptr + 23'd2;  end
      DRAIN: begin bus.mem_req = 1'b1;  bus.mem_addr = dr_addr;      end
      default: ;
    endcase
  end

  // Control events in priority order; all three collapse into "go to address" or "go idle".
  always_comb begin
    ev      = 1'b0;
    ev_idle = 1'b0;
    ev_addr = START_ADDR;
    if (field_start) begin
      ev = 1'b1;
    end else if (stop) begin
      ev      = 1'b1;
      ev_idle = 1'b1;
    end else if (reload_valid) begin
      ev      = 1'b1;
      ev_addr = reload_addr & ~23'd1;
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    hi_d      = hi;
    dr_addr_d = dr_addr;
    dr_tgt_d  = dr_tgt;
    dr_idle_d = dr_idle;
    flush     = 1'b0;
    push      = 1'b0;
    if (state == IDLE) begin
      if (field_start) begin
        ptr_d   = START_ADDR;
        flush   = 1'b1;
        state_d = RD_HI;
      end
    end else if (ev) begin
      flush = 1'b1;
      if (outstanding) begin
        // The bus cycle cannot be aborted: park the target and finish the access in DRAIN.
        state_d   = DRAIN;
        dr_addr_d = bus.mem_addr;
        dr_tgt_d  = ev_addr;
        dr_idle_d = ev_idle;
      end else if (ev_idle) begin
        state_d = IDLE;
      end else begin
        state_d = RD_HI;
        ptr_d   = ev_addr;
      end
    end else begin
      unique case (state)
        RD_HI: if (bus.mem_req && bus.mem_ack) begin
          hi_d    = bus.mem_data;
          state_d = RD_LO;
        end
        RD_LO: if (bus.mem_ack) begin
          push    = 1'b1;
          ptr_d   = ptr + 23'd4;
          state_d = RD_HI;
        end
        DRAIN: if (bus.mem_ack) begin
          if (dr_idle) begin
            state_d = IDLE;
          end else begin
            state_d = RD_HI;
            ptr_d   = dr_tgt;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= START_ADDR;
      hi      <= '0;
      dr_addr <= '0;
      dr_tgt  <= '0;
      dr_idle <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      hi      <= hi_d;
      dr_addr <= dr_addr_d;
      dr_tgt  <= dr_tgt_d;
      dr_idle <= dr_idle_d;
    end
  end

  // A flush overrides a same-cycle pop; the popped instruction still counts as accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {hi, bus.mem_data};
  end

endmodule

// File: tb/tb_dcp_instruction_fetch.sv
// Scoreboard bench for dcp_instruction_fetch: expected RAM addresses and delivered
// instructions are queued by the stimulus and consumed by independent monitors.
module tb_dcp_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        field_start, reload_valid, stop, busy;
  logic [22:0] reload_addr;

  dcp_instruction_fetch_if bus_if ();

  dcp_instruction_fetch #(.START_ADDR(23'h000400), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .field_start  (field_start),
    .bus          (bus_if.master),
    .reload_valid (reload_valid),
    .reload_addr  (reload_addr),
    .stop         (stop),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          lat   = 0;
  int          wcnt  = 0;
  logic [22:0] exp_addr [$];
  logic [31:0] exp_instr [$];
  logic        prev_pend = 1'b0;
  logic [22:0] prev_addr = '0;

  function automatic logic [15:0] mword(input logic [22:0] a);
    case (a)
      23'h000400: mword = 16'h1234;
      23'h000402: mword = 16'h5678;
      23'h000404: mword = 16'h9ABC;
      23'h000406: mword = 16'hDEF0;
      default:    mword = a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  // RAM model: ack once the request has waited lat cycles (lat=0 acks in the first cycle).
  assign bus_if.mem_ack  = bus_if.mem_req && (wcnt >= lat);
  assign bus_if.mem_data = mword(bus_if.mem_addr);

  always @(posedge clk) begin
    if (!bus_if.mem_req || bus_if.mem_ack) wcnt <= 0;
    else                                   wcnt <= wcnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Address monitor plus request-stability check.
  always @(negedge clk) begin
    logic [22:0] ea;
    if (reset_n) begin
      if (prev_pend)
        chk("req_hold", {8'd0, bus_if.mem_req, bus_if.mem_addr}, {8'd0, 1'b1, prev_addr});
      if (bus_if.mem_req && bus_if.mem_ack) begin
        if (exp_addr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_access: got %h want none", bus_if.mem_addr);
        end else begin
          ea = exp_addr.pop_front();
          chk("mem_addr", {9'd0, bus_if.mem_addr}, {9'd0, ea});
        end
      end
    end
    prev_pend = reset_n && bus_if.mem_req && !bus_if.mem_ack;
    prev_addr = bus_if.mem_addr;
  end

  // Instruction monitor.
  always @(negedge clk) begin
    logic [31:0] ei;
    if (reset_n && bus_if.instr_valid && bus_if.instr_ready) begin
      if (exp_instr.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_instr: got %h want none", bus_if.instr_data);
      end else begin
        ei = exp_instr.pop_front();
        chk("instr_data", bus_if.instr_data, ei);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic f, input logic s, input logic r);
    field_start = f; stop = s; reload_valid = r;
    tick(1);
    field_start = 1'b0; stop = 1'b0; reload_valid = 1'b0;
  endtask

  task automatic push_fetch400();
    exp_addr.push_back(23'h000400); exp_addr.push_back(23'h000402);
    exp_addr.push_back(23'h000404); exp_addr.push_back(23'h000406);
  endtask

  task automatic pop_one();
    bus_if.instr_ready = 1'b1;
    tick(1);
    bus_if.instr_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; field_start = 1'b0; reload_valid = 1'b0; stop = 1'b0;
    reload_addr = '0; bus_if.instr_ready = 1'b0;
    #1;
    chk("rst_req",   {31'd0, bus_if.mem_req}, 32'd0);
    chk("rst_addr",  {9'd0, bus_if.mem_addr}, 32'd0);
    chk("rst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    chk("rst_data",  bus_if.instr_data, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Basic fetch from 0x400, FIFO fills to 2 with executor stalled.
    lat = 0;
    push_fetch400();
    pulse(1'b1, 1'b0, 1'b0);
    chk("first_req",  {31'd0, bus_if.mem_req}, 32'd1);
    chk("first_addr", {9'd0, bus_if.mem_addr}, 32'h400);
    chk("busy_run",   {31'd0, busy}, 32'd1);
    tick(12);
    chk("full_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    chk("full_head",  bus_if.instr_data, 32'h12345678);
    tick(5);
    chk("full_noreq", {31'd0, bus_if.mem_req}, 32'd0);

    // One pop frees a slot: next fetch at 0x408 (held off by RAM latency).
    lat = 1000;
    exp_instr.push_back(32'h12345678);
    exp_addr.push_back(23'h000408);
    pop_one();
    chk("second_head", bus_if.instr_data, 32'h9ABCDEF0);
    chk("refetch_req", {31'd0, bus_if.mem_req}, 32'd1);
    chk("refetch_addr", {9'd0, bus_if.mem_addr}, 32'h408);

    // Stop while the 0x408 read is outstanding: drain, then idle.
    pulse(1'b0, 1'b1, 1'b0);
    chk("drain_busy",  {31'd0, busy}, 32'd1);
    chk("drain_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    tick(2);
    chk("drain_addr",  {9'd0, bus_if.mem_addr}, 32'h408);
    lat = 0;
    tick(1);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_req",  {31'd0, bus_if.mem_req}, 32'd0);
    tick(3);

    // Restart at 0x400 after stop.
    push_fetch400();
    pulse(1'b1, 1'b0, 1'b0);
    tick(12);
    chk("restart_head", bus_if.instr_data, 32'h12345678);

    // Reload while RD_LO waits on the 0x40A read.
    lat = 1000;
    exp_instr.push_back(32'h12345678);
    exp_addr.push_back(23'h000408);
    exp_addr.push_back(23'h00040A);
    pop_one();
    lat = 0;
    tick(1);
    lat = 1000;
    tick(5);
    chk("rdlo_addr", {9'd0, bus_if.mem_addr}, 32'h40A);
    exp_addr.push_back(23'h001000);
    reload_addr = 23'h001001;
    pulse(1'b0, 1'b0, 1'b1);
    bus_if.instr_ready = 1'b1;
    chk("reload_valid0", {31'd0, bus_if.instr_valid}, 32'd0);
    tick(3);
    chk("reload_hold", {9'd0, bus_if.mem_addr}, 32'h40A);
    lat = 0;
    tick(1);
    lat = 1000;
    chk("reload_addr",  {9'd0, bus_if.mem_addr}, 32'h1000);
    chk("reload_req",   {31'd0, bus_if.mem_req}, 32'd1);
    chk("reload_stale", {31'd0, bus_if.instr_valid}, 32'd0);

    // Reload to the top of memory: address wraps to 0.
    bus_if.instr_ready = 1'b0;
    exp_addr.push_back(23'h7FFFFC); exp_addr.push_back(23'h7FFFFE);
    exp_addr.push_back(23'h000000); exp_addr.push_back(23'h000002);
    reload_addr = 23'h7FFFFC;
    pulse(1'b0, 1'b0, 1'b1);
    lat = 0;
    tick(14);
    chk("wrap_head", bus_if.instr_data, 32'hA5A6A5A4);
    chk("wrap_noreq", {31'd0, bus_if.mem_req}, 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("wrap_stop_busy", {31'd0, busy}, 32'd0);

    // field_start + stop + reload together while an access is outstanding.
    lat = 1000;
    exp_addr.push_back(23'h000400);
    pulse(1'b1, 1'b0, 1'b0);
    reload_addr = 23'h002000;
    pulse(1'b1, 1'b1, 1'b1);
    chk("triple_busy", {31'd0, busy}, 32'd1);
    chk("triple_hold", {9'd0, bus_if.mem_addr}, 32'h400);
    push_fetch400();
    lat = 0;
    tick(14);
    chk("triple_head", bus_if.instr_data, 32'h12345678);

    // Asynchronous reset in the middle of an access.
    lat = 1000;
    exp_instr.push_back(32'h12345678);
    pop_one();
    chk("pre_rst_req", {31'd0, bus_if.mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, bus_if.mem_req}, 32'd0);
    chk("arst_addr",  {9'd0, bus_if.mem_addr}, 32'd0);
    chk("arst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    chk("arst_data",  bus_if.instr_data, 32'd0);
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    tick(1);
    reset_n = 1'b1;
    lat = 0;
    tick(1);
    push_fetch400();
    pulse(1'b1, 1'b0, 1'b0);
    tick(14);
    chk("post_rst_head", bus_if.instr_data, 32'h12345678);

    chk("addr_queue_left",  exp_addr.size(), 32'd0);
    chk("instr_queue_left", exp_instr.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcp_instruction_fetch.md
Name: dcp_instruction_fetch

Overview:
Fetch unit that feeds the display control program (DCP) executor of the MCD212 image display control path.
- At each field start it reads 32-bit control instructions from system RAM, beginning at the field start address.
- System RAM is accessed over a 16-bit request/acknowledge read port.
- Instructions are buffered in a small FIFO and presented to the executor over a valid/ready interface.
- The executor's control requests are honoured: reload DCP pointer (jump), stop until next field.

Parameters:
START_ADDR, 23'h000400, byte address where instruction fetch begins at each field start.
FIFO_DEPTH, 2, instruction FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
field_start  in  1  one-cycle pulse at start of field (vertical blank boundary).
mem_req  out  1  read request to RAM arbiter.
mem_addr  out  23  byte address of the 16-bit read; bit 0 always 0.
mem_ack  in  1  read complete; mem_data is valid in the same cycle.
mem_data  in  16  read data.
instr_valid  out  1  FIFO head holds an instruction.
instr_data  out  32  FIFO head instruction; bits 31:28 are the opcode.
instr_ready  in  1  executor accepts the head instruction.
reload_valid  in  1  one-cycle pulse: flush, then continue fetching at reload_addr.
reload_addr  in  23  new fetch address; bit 0 is ignored.
stop  in  1  one-cycle pulse: flush and halt until the next field_start.
busy  out  1  state is not IDLE.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, instr_valid=0, instr_data=0, busy=0, FIFO empty, state IDLE, fetch pointer = START_ADDR.
- States: IDLE, RD_HI, RD_LO, DRAIN.
- IDLE: on field_start, pointer <= START_ADDR, flush FIFO, go to RD_HI. Ignores reload_valid and stop.
- RD_HI: mem_req=1, mem_addr=pointer.
  - On mem_ack, latch mem_data into bits 31:16 and go to RD_LO.
  - mem_req first asserts the cycle after field_start.
  - mem_req and mem_addr stay stable until mem_ack.
- RD_LO: mem_req=1, mem_addr=pointer+2.
  - On mem_ack, write {hi, mem_data} to the FIFO and set pointer <= pointer+4.
  - Then go to RD_HI if the FIFO will have a free entry, else wait in RD_HI with mem_req=0.
  - Never requests a word without space for the full instruction.
- Address arithmetic is modulo 2^23; pointer 23'h7FFFFC + 4 wraps to 0.
- FIFO:
  - Write and pop in the same cycle are allowed, including when full.
  - Output is registered from the FIFO head.
  - An instruction written at cycle N shows instr_valid=1 at cycle N+1.
  - Pop occurs when instr_valid && instr_ready.
- reload_valid (state not IDLE):
  - Flush the FIFO immediately; instr_valid=0 the next cycle.
  - If no access is outstanding, go to RD_HI at reload_addr with bit 0 cleared.
  - If an access is outstanding (mem_req=1, no ack yet), go to DRAIN. The bus cycle cannot be aborted: keep mem_req/mem_addr until mem_ack, discard the data, then go to RD_HI at the reload address.
- stop (state not IDLE):
  - Flush the FIFO.
  - If idle on the bus, go to IDLE.
  - If an access is outstanding, go to DRAIN and then to IDLE after the ack.
- DRAIN:
  - Holds the pending target (reload address or IDLE).
  - A later reload_valid or stop overwrites the target.
  - A field_start overwrites the target with START_ADDR fetch.
- Priority for same-cycle events: field_start > stop > reload_valid > normal operation.
  - field_start while a fetch is active behaves as a reload to START_ADDR, including the DRAIN rule.
- Pop and flush in the same cycle: the flush wins; the pop is counted as accepted.
- busy=1 in RD_HI, RD_LO and DRAIN.
- Asynchronous reset mid-access drops mem_req immediately; no draining is required.

Test Plan:
- RAM words 0x400=1234, 0x402=5678, 0x404=9ABC, 0x406=DEF0; field_start; 1-cycle ack -> instr_data 0x12345678 then 0x9ABCDEF0; mem_addr sequence 400, 402, 404, 406.
- instr_ready=0, FIFO_DEPTH=2 -> exactly 4 acks (2 instructions); mem_req stays 0 until one pop; after the pop, mem_addr=0x408.
- reload_valid with reload_addr=0x1001 while RD_LO is waiting 5 cycles for ack -> mem_addr holds 0x402 until ack; that data is not delivered; next mem_addr=0x1000; no stale instr_valid.
- stop during RD_HI with ack delayed 3 cycles -> DRAIN, then IDLE; mem_req=0 and busy=0 afterwards; field_start then restarts fetch at 0x400.
- Start at 0x7FFFFC via reload -> fetches 7FFFFC, 7FFFFE, then 000000.
- field_start, stop and reload_valid in the same cycle; separately, reset_n low mid-access -> fetch starts at 0x400; reset clears mem_req asynchronously and sets all outputs to their reset values.
